// File: rtl/axi_copy_pkg.sv
// Shared types and helpers for the AXI copy controller: FSM states and burst-size arithmetic.
package axi_copy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int unsigned BEAT_BYTES = 4;
  localparam int unsigned PAGE_BYTES = 4096;

  function automatic logic [31:0] min_u(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

  // Words left before the next 4 KiB page boundary, counted from a word-aligned offset.
  function automatic logic [31:0] b4k(input logic [11:0] a);
    return (PAGE_BYTES - 32'(a)) / BEAT_BYTES;
  endfunction

endpackage

// File: rtl/copy_fifo.sv
// Show-ahead staging FIFO: dout is the head entry whenever empty is low.
module copy_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  // Illegal push/pop are dropped here; the controller flags them.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      if (do_pop)  rptr_q <= (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/axi_copy_ctrl.sv
// Memory-to-memory copy engine: splits a copy command into 4 KiB-safe read bursts,
// stages the data in a FIFO and replays it as matching write bursts.
module axi_copy_ctrl
  import axi_copy_pkg::*;
#(
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 20,
  parameter int CNT_W      = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [CNT_W-1:0]  cmd_words,
  output logic              busy,
  output logic              done,
  output logic              proto_err,
  output logic              rd_req,
  output logic [8:0]        rd_len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_last,
  input  logic              rd_data_en,
  input  logic [31:0]       rd_data,
  output logic              wr_req,
  output logic [8:0]        wr_len,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_last,
  input  logic              wr_data_en,
  output logic [2:0]        dbg_state
);

  // Request handshake: rd_req/wr_req are levels raised when a burst is ready and
  // dropped on the first data beat of that burst (rd_data_en / wr_data_en).

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [8:0]        n_q, n_d, beat_q, beat_d;
  logic [8:0]        rd_len_q, rd_len_d, wr_len_q, wr_len_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic              rd_req_q, rd_req_d, wr_req_q, wr_req_d;
  logic              proto_err_q, proto_err_d;
  logic [8:0]        n_calc;
  logic [ADDR_W-1:0] step;
  logic              fifo_push, fifo_full, fifo_empty;

  assign n_calc = 9'(min_u(min_u(32'(rem_q), 32'(MAX_BURST)),
                           min_u(b4k(src_q[11:0]), b4k(dst_q[11:0]))));
  assign step   = ADDR_W'({n_q, 2'b00});

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= ST_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      n_q         <= '0;
      beat_q      <= '0;
      rd_len_q    <= '0;
      wr_len_q    <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      n_q         <= n_d;
      beat_q      <= beat_d;
      rd_len_q    <= rd_len_d;
      wr_len_q    <= wr_len_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    n_d         = n_q;
    beat_d      = beat_q;
    rd_len_d    = rd_len_q;
    wr_len_d    = wr_len_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    rd_req_d    = rd_req_q;
    wr_req_d    = wr_req_q;
    fifo_push   = 1'b0;
    proto_err_d = proto_err_q | (wr_data_en & fifo_empty);
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          src_d   = cmd_src & ~ADDR_W'(3);
          dst_d   = cmd_dst & ~ADDR_W'(3);
          rem_d   = cmd_words;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (rem_q == '0) begin
          state_d = ST_DONE;
        end else begin
          n_d       = n_calc;
          rd_len_d  = n_calc - 9'd1;
          wr_len_d  = n_calc - 9'd1;
          rd_addr_d = src_q;
          wr_addr_d = dst_q;
          beat_d    = '0;
          rd_req_d  = 1'b1;
          state_d   = ST_RD;
        end
      end
      ST_RD: begin
        if (rd_data_en) begin
          fifo_push   = 1'b1;
          proto_err_d = proto_err_d | fifo_full;
          rd_req_d    = 1'b0;
          beat_d      = beat_q + 9'd1;
          if (rd_last) begin
            // A short or long burst still moves on so the engine cannot wedge.
            if (beat_q + 9'd1 != n_q) proto_err_d = 1'b1;
            src_d    = src_q + step;
            beat_d   = '0;
            wr_req_d = 1'b1;
            state_d  = ST_WR;
          end
        end
      end
      ST_WR: begin
        if (wr_data_en) begin
          wr_req_d = 1'b0;
          if (wr_last) begin
            dst_d   = dst_q + step;
            rem_d   = rem_q - CNT_W'(n_q);
            state_d = ST_CALC;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  copy_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .push  (fifo_push),
    .pop   (wr_data_en),
    .din   (rd_data),
    .dout  (wr_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign proto_err = proto_err_q;
  assign rd_req    = rd_req_q;
  assign rd_len    = rd_len_q;
  assign rd_addr   = rd_addr_q;
  assign wr_req    = wr_req_q;
  assign wr_len    = wr_len_q;
  assign wr_addr   = wr_addr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_copy_ctrl.sv
// Directed bench for axi_copy_ctrl: plays the adapter side of the rd_*/wr_* interface
// and checks burst geometry, data order, latency, reset and error flagging.
module tb_axi_copy_ctrl;

  logic        ACLK, ARESETn;
  logic        cmd_valid, cmd_ready;
  logic [19:0] cmd_src, cmd_dst;
  logic [15:0] cmd_words;
  logic        busy, done, proto_err;
  logic        rd_req, rd_last, rd_data_en;
  logic [8:0]  rd_len, wr_len;
  logic [19:0] rd_addr, wr_addr;
  logic [31:0] rd_data, wr_data;
  logic        wr_req, wr_last, wr_data_en;
  logic [2:0]  dbg_state;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [11:0] tag;
  int          lat;

  axi_copy_ctrl #(
    .MAX_BURST(16), .FIFO_DEPTH(16), .ADDR_W(20), .CNT_W(16)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_words(cmd_words),
    .busy(busy), .done(done), .proto_err(proto_err),
    .rd_req(rd_req), .rd_len(rd_len), .rd_addr(rd_addr),
    .rd_last(rd_last), .rd_data_en(rd_data_en), .rd_data(rd_data),
    .wr_req(wr_req), .wr_len(wr_len), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_last(wr_last), .wr_data_en(wr_data_en),
    .dbg_state(dbg_state)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_rd_len", rd_len, 0);
    chk("rst_wr_len", wr_len, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_state", dbg_state, 0);
  endtask

  // Ends on the negedge of the CALC cycle.
  task automatic send_cmd(input logic [19:0] src, input logic [19:0] dst, input logic [15:0] words);
    @(negedge ACLK);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_src = src; cmd_dst = dst; cmd_words = words;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("cmd_ready_busy", cmd_ready, 0);
    chk("rd_req_in_calc", rd_req, 0);
  endtask

  task automatic read_burst(input logic [19:0] addr, input logic [8:0] len, input int nbeats,
                            input int gapmax, output int lat_o);
    lat_o = 0;
    while (rd_req !== 1'b1 && lat_o < 50) begin @(negedge ACLK); lat_o++; end
    chk("rd_req_seen", rd_req, 1);
    chk("rd_addr", rd_addr, addr);
    chk("rd_len", rd_len, len);
    for (int b = 0; b < nbeats; b++) begin
      if (gapmax > 0) repeat ($urandom_range(gapmax, 0)) @(negedge ACLK);
      rd_data_en = 1'b1;
      rd_data    = {tag, 20'(addr + 20'(4 * b))};
      rd_last    = (b == nbeats - 1);
      exp_q.push_back(rd_data);
      @(negedge ACLK);
      rd_data_en = 1'b0;
      rd_last    = 1'b0;
      if (b == 0) chk("rd_req_drop", rd_req, 0);
    end
  endtask

  task automatic write_burst(input logic [19:0] addr, input logic [8:0] len, input int nbeats,
                             input int gapmax, input int first_delay, input int nchk);
    int w = 0;
    int held = 0;
    while (wr_req !== 1'b1 && w < 50) begin @(negedge ACLK); w++; end
    chk("wr_req_seen", wr_req, 1);
    chk("wr_addr", wr_addr, addr);
    chk("wr_len", wr_len, len);
    for (int i = 0; i < first_delay; i++) begin
      @(negedge ACLK);
      if (wr_req === 1'b1) held++;
    end
    if (first_delay > 0) chk("wr_req_held", held, first_delay);
    for (int b = 0; b < nbeats; b++) begin
      if (b > 0 && gapmax > 0) repeat ($urandom_range(gapmax, 0)) @(negedge ACLK);
      if (b < nchk) begin
        chk("exp_q_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("wr_data", wr_data, exp_q.pop_front());
      end
      wr_data_en = 1'b1;
      wr_last    = (b == int'(len));
      @(negedge ACLK);
      wr_data_en = 1'b0;
      wr_last    = 1'b0;
      if (b == 0) chk("wr_req_drop", wr_req, 0);
    end
  endtask

  task automatic wait_done();
    int w = 0;
    while (done !== 1'b1 && w < 10) begin @(negedge ACLK); w++; end
    chk("done_pulse", done, 1);
    chk("exp_q_drained", exp_q.size(), 0);
    @(negedge ACLK);
    chk("done_low", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    ARESETn = 1'b0; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_words = '0;
    rd_last = 1'b0; rd_data_en = 1'b0; rd_data = '0;
    wr_last = 1'b0; wr_data_en = 1'b0;
    tag = 12'hA01;
    repeat (3) @(negedge ACLK);
    check_reset_values();
    ARESETn = 1'b1;

    // Single burst, including request latencies
    send_cmd(20'h00100, 20'h08000, 16'd8);
    read_burst(20'h00100, 9'd7, 8, 0, lat);
    chk("rd_req_latency", lat, 1);
    chk("wr_req_after_rd", wr_req, 1);
    write_burst(20'h08000, 9'd7, 8, 0, 0, 8);
    wait_done();

    // Multi-burst
    tag = 12'hB02;
    send_cmd(20'h00000, 20'h02000, 16'd40);
    read_burst(20'h00000, 9'd15, 16, 0, lat);
    write_burst(20'h02000, 9'd15, 16, 0, 0, 16);
    read_burst(20'h00040, 9'd15, 16, 0, lat);
    write_burst(20'h02040, 9'd15, 16, 0, 0, 16);
    read_burst(20'h00080, 9'd7, 8, 0, lat);
    write_burst(20'h02080, 9'd7, 8, 0, 0, 8);
    wait_done();

    // 4 KiB split on the source side
    tag = 12'hC03;
    send_cmd(20'h00FF8, 20'h04000, 16'd8);
    read_burst(20'h00FF8, 9'd1, 2, 0, lat);
    write_burst(20'h04000, 9'd1, 2, 0, 0, 2);
    read_burst(20'h01000, 9'd5, 6, 0, lat);
    write_burst(20'h04008, 9'd5, 6, 0, 0, 6);
    wait_done();

    // Zero words: done two cycles after accept, no requests
    send_cmd(20'h00400, 20'h05000, 16'd0);
    @(negedge ACLK);
    chk("zero_done", done, 1);
    chk("zero_rd_req", rd_req, 0);
    chk("zero_wr_req", wr_req, 0);
    @(negedge ACLK);
    chk("zero_done_low", done, 0);
    chk("zero_busy", busy, 0);

    // Backpressure with random gaps and a 10-cycle first write delay
    tag = 12'hD04;
    send_cmd(20'h00503, 20'h0B001, 16'd20);
    read_burst(20'h00500, 9'd15, 16, 3, lat);
    write_burst(20'h0B000, 9'd15, 16, 3, 10, 16);
    read_burst(20'h00540, 9'd3, 4, 3, lat);
    write_burst(20'h0B040, 9'd3, 4, 3, 10, 4);
    wait_done();
    chk("bp_proto_err", proto_err, 0);

    // Reset during beat 3 of an 8-beat write
    tag = 12'hE05;
    send_cmd(20'h00200, 20'h09000, 16'd8);
    read_burst(20'h00200, 9'd7, 8, 0, lat);
    write_burst(20'h09000, 9'd7, 3, 0, 0, 3);
    ARESETn = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    @(negedge ACLK);
    ARESETn = 1'b1;
    tag = 12'hF06;
    send_cmd(20'h00300, 20'h0A000, 16'd8);
    read_burst(20'h00300, 9'd7, 8, 0, lat);
    write_burst(20'h0A000, 9'd7, 8, 0, 0, 8);
    wait_done();
    chk("post_rst_proto_err", proto_err, 0);

    // rd_last on beat 2 of 4: flagged, engine still finishes, flag is sticky
    tag = 12'h707;
    send_cmd(20'h00600, 20'h0C000, 16'd4);
    read_burst(20'h00600, 9'd3, 2, 0, lat);
    chk("early_last_err", proto_err, 1);
    chk("early_last_wr_req", wr_req, 1);
    write_burst(20'h0C000, 9'd3, 4, 0, 0, 2);
    wait_done();
    chk("proto_err_sticky", proto_err, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout: got=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "simulation time limit reached");
  end

endmodule
